alu_seq: RTL and testbench

- Parametrised, registered successor to the team's combinational ALU.
- Adds a valid/ready handshake on both sides, a widened op set (shifts, compares, iterative multiply) and a full flag set (zero, negative, carry, overflow, illegal-op).
- Sits between the UART command decoder (operand/op producer) and the UART response formatter (result consumer).

---
 rtl/alu_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops produce a result on the accept edge. MUL runs a
// shift-and-add loop, one multiplier bit per cycle. Results are held
// in DONE until the consumer takes them.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       flags_o
);

    // Shift-amount width is tied to WIDTH and cannot be overridden.
    localparam int SHW = $clog2(WIDTH);

    // Operation encodings as presented on op_i.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    // The multiply loop starts at WIDTH. DONE is entered on the edge
    // where the counter steps from one to zero.
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            r_state;
    stateT            w_nextState;

    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_flags;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [SHW:0]     r_count;

    logic             w_accept;
    logic             w_isMul;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH:0]   w_addFull;
    logic [WIDTH:0]   w_subFull;
    logic [WIDTH-1:0] w_aluResult;
    logic [4:0]       w_aluFlags;
    logic             w_aluCarry;
    logic             w_aluOverflow;
    logic             w_aluIllegal;
    logic [WIDTH-1:0] w_accNext;
    logic             w_mulLast;

    // A new op can enter when idle, or when the held result is being
    // consumed on this same edge (back-to-back issue without a bubble).
    assign in_ready_o  = (r_state == IDLE) | ((r_state == DONE) & out_ready_i);
    assign out_valid_o = (r_state == DONE);
    assign result_o    = r_result;
    assign flags_o     = r_flags;

    assign w_accept  = in_valid_i & in_ready_o;
    assign w_isMul   = (op_i == OP_MUL);
    assign w_shamt   = b_i[SHW-1:0];

    // The extra top bit of the add is the carry-out. The extra top bit
    // of the subtract is the borrow, which is set exactly when a < b unsigned.
    assign w_addFull = {1'b0, a_i} + {1'b0, b_i};
    assign w_subFull = {1'b0, a_i} - {1'b0, b_i};

    // One shift-and-add step: add the multiplicand when the current
    // multiplier LSB is set. Wraps modulo 2^WIDTH.
    assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mulLast = (r_count == CNT_LAST);

    // Combinational result and flags for every op that completes on the accept edge.
    always_comb begin
        w_aluResult   = '0;
        w_aluCarry    = 1'b0;
        w_aluOverflow = 1'b0;
        w_aluIllegal  = 1'b0;
        case (op_i)
            OP_ADD: begin
                w_aluResult   = w_addFull[WIDTH-1:0];
                w_aluCarry    = w_addFull[WIDTH];
                w_aluOverflow = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                                (w_addFull[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                w_aluResult   = w_subFull[WIDTH-1:0];
                w_aluCarry    = w_subFull[WIDTH];
                w_aluOverflow = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                                (w_subFull[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  w_aluResult = a_i & b_i;
            OP_OR:   w_aluResult = a_i | b_i;
            OP_XOR:  w_aluResult = a_i ^ b_i;
            OP_SLL:  w_aluResult = a_i << w_shamt;
            OP_SRL:  w_aluResult = a_i >> w_shamt;
            OP_SRA:  w_aluResult = $signed(a_i) >>> w_shamt;
            OP_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: w_aluResult = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            OP_MUL:  w_aluResult = '0;
            default: w_aluIllegal = 1'b1;
        endcase
        w_aluFlags = {w_aluIllegal, w_aluOverflow, w_aluCarry,
                      w_aluResult[WIDTH-1], (w_aluResult == '0)};
    end

    // State register. Reset discards any op in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. An accepted op goes to BUSY for MUL and to DONE otherwise.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_isMul ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (w_mulLast) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (w_accept) begin
                    w_nextState = w_isMul ? BUSY : DONE;
                end else if (out_ready_i) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath registers: capture single-cycle results or MUL operands on
    // accept, and step the multiply loop while BUSY. The result and flags
    // only change on those events, so they stay stable while held in DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_result <= '0;
            r_flags  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            if (w_isMul) begin
                r_mcand  <= a_i;
                r_mplier <= b_i;
                r_acc    <= '0;
                r_count  <= CNT_INIT;
            end else begin
                r_result <= w_aluResult;
                r_flags  <= w_aluFlags;
            end
        end else if (r_state == BUSY) begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CNT_LAST;
            if (w_mulLast) begin
                r_result <= w_accNext;
                r_flags  <= {3'b000, w_accNext[WIDTH-1], (w_accNext == '0)};
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=32.
module tb_alu_seq;

    logic        clk;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic [3:0]  opIn;
    logic        outValid;
    logic        outReady;
    logic [31:0] result;
    logic [4:0]  flags;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .a_i         (aIn),
        .b_i         (bIn),
        .op_i        (opIn),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .result_o    (result),
        .flags_o     (flags)
    );

    // Free-running clock with a 10-time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op for a single accept edge, then drop in_valid.
    // Returns 1 time unit after the edge, when outputs are sampled.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        opIn    = op;
        aIn     = a;
        bIn     = b;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic test_reset();
        rstN     = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        aIn      = '0;
        bIn      = '0;
        opIn     = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", inReady); end
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", outValid); end
        total++; if (result !== 32'h0) begin bad++; $display("[TB] FAIL reset_result got=%h want=0", result); end
        total++; if (flags !== 5'b0) begin bad++; $display("[TB] FAIL reset_flags got=%b want=00000", flags); end
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_wrap();
        outReady = 1'b1;
        applyStimulus(4'd0, 32'hFFFF_FFFF, 32'h1);
        total++; if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL add_valid got=%b want=1", outValid); end
        total++; if (result !== 32'h0) begin bad++; $display("[TB] FAIL add_result got=%h want=00000000", result); end
        total++; if (flags !== 5'b00101) begin bad++; $display("[TB] FAIL add_flags got=%b want=00101", flags); end
        @(posedge clk);
        #1;
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL add_drain got=%b want=0", outValid); end
    endtask

    task automatic test_sub_compare();
        outReady = 1'b1;
        applyStimulus(4'd1, 32'h8000_0000, 32'h1);
        total++; if (result !== 32'h7FFF_FFFF) begin bad++; $display("[TB] FAIL sub_result got=%h want=7fffffff", result); end
        total++; if (flags !== 5'b01000) begin bad++; $display("[TB] FAIL sub_flags got=%b want=01000", flags); end
        applyStimulus(4'd8, 32'hFFFF_FFFF, 32'h0);
        total++; if (result !== 32'h1) begin bad++; $display("[TB] FAIL slt_result got=%h want=00000001", result); end
        total++; if (flags !== 5'b00000) begin bad++; $display("[TB] FAIL slt_flags got=%b want=00000", flags); end
        applyStimulus(4'd9, 32'hFFFF_FFFF, 32'h0);
        total++; if (result !== 32'h0) begin bad++; $display("[TB] FAIL sltu_result got=%h want=00000000", result); end
        total++; if (flags !== 5'b00001) begin bad++; $display("[TB] FAIL sltu_flags got=%b want=00001", flags); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_shifts();
        outReady = 1'b1;
        applyStimulus(4'd7, 32'h8000_0000, 32'h21);
        total++; if (result !== 32'hC000_0000) begin bad++; $display("[TB] FAIL sra_result got=%h want=c0000000", result); end
        total++; if (flags !== 5'b00010) begin bad++; $display("[TB] FAIL sra_flags got=%b want=00010", flags); end
        applyStimulus(4'd6, 32'h8000_0000, 32'h21);
        total++; if (result !== 32'h4000_0000) begin bad++; $display("[TB] FAIL srl_result got=%h want=40000000", result); end
        applyStimulus(4'd5, 32'h1, 32'd31);
        total++; if (result !== 32'h8000_0000) begin bad++; $display("[TB] FAIL sll_result got=%h want=80000000", result); end
        total++; if (flags !== 5'b00010) begin bad++; $display("[TB] FAIL sll_flags got=%b want=00010", flags); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_mul();
        logic stayedIdle;
        outReady = 1'b0;
        applyStimulus(4'd10, 32'd7, 32'd9);
        total++; if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL mulrst_busy_ready got=%b want=0", inReady); end
        repeat (5) @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL mulrst_in_ready got=%b want=1", inReady); end
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL mulrst_out_valid got=%b want=0", outValid); end
        total++; if (result !== 32'h0) begin bad++; $display("[TB] FAIL mulrst_result got=%h want=00000000", result); end
        total++; if (flags !== 5'b0) begin bad++; $display("[TB] FAIL mulrst_flags got=%b want=00000", flags); end
        #2;
        rstN = 1'b1;
        stayedIdle = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (outValid !== 1'b0 || inReady !== 1'b1) stayedIdle = 1'b0;
        end
        total++; if (stayedIdle !== 1'b1) begin bad++; $display("[TB] FAIL mulrst_after_release got=%b want=1", stayedIdle); end
    endtask

    task automatic test_mul_backpressure();
        int   cycles;
        logic busyOk;
        logic holdOk;
        outReady = 1'b0;
        applyStimulus(4'd10, 32'd12345, 32'd6789);
        cycles = 1;
        busyOk = 1'b1;
        while (outValid !== 1'b1 && cycles < 40) begin
            if (inReady !== 1'b0) busyOk = 1'b0;
            if (cycles == 2) begin
                opIn    = 4'd0;
                inValid = 1'b1;
            end
            if (cycles == 10) inValid = 1'b0;
            aIn = $urandom;
            bIn = $urandom;
            @(posedge clk);
            #1;
            cycles++;
        end
        total++; if (cycles != 33) begin bad++; $display("[TB] FAIL mul_latency got=%0d want=33", cycles); end
        total++; if (busyOk !== 1'b1) begin bad++; $display("[TB] FAIL mul_busy_not_ready got=%b want=1", busyOk); end
        total++; if (result !== 32'd83810205) begin bad++; $display("[TB] FAIL mul_result got=%0d want=83810205", result); end
        total++; if (flags !== 5'b00000) begin bad++; $display("[TB] FAIL mul_flags got=%b want=00000", flags); end
        holdOk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (outValid !== 1'b1 || inReady !== 1'b0 ||
                result !== 32'd83810205 || flags !== 5'b00000) holdOk = 1'b0;
        end
        total++; if (holdOk !== 1'b1) begin bad++; $display("[TB] FAIL mul_hold got=%b want=1", holdOk); end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL mul_release_valid got=%b want=0", outValid); end
        total++; if (result !== 32'd83810205) begin bad++; $display("[TB] FAIL mul_release_result got=%0d want=83810205", result); end
    endtask

    task automatic test_back_to_back();
        outReady = 1'b1;
        opIn     = 4'd0;
        aIn      = 32'd1;
        bIn      = 32'd2;
        inValid  = 1'b1;
        @(posedge clk);
        #1;
        total++; if (outValid !== 1'b1 || result !== 32'd3) begin bad++; $display("[TB] FAIL b2b_add got=%b/%h want=1/00000003", outValid, result); end
        total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready got=%b want=1", inReady); end
        opIn = 4'd4;
        aIn  = 32'hF0;
        bIn  = 32'hFF;
        @(posedge clk);
        #1;
        total++; if (outValid !== 1'b1 || result !== 32'h0F) begin bad++; $display("[TB] FAIL b2b_xor got=%b/%h want=1/0000000f", outValid, result); end
        total++; if (flags !== 5'b00000) begin bad++; $display("[TB] FAIL b2b_xor_flags got=%b want=00000", flags); end
        opIn = 4'd12;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        total++; if (outValid !== 1'b1 || result !== 32'h0) begin bad++; $display("[TB] FAIL b2b_illegal got=%b/%h want=1/00000000", outValid, result); end
        total++; if (flags !== 5'b10001) begin bad++; $display("[TB] FAIL b2b_illegal_flags got=%b want=10001", flags); end
        @(posedge clk);
        #1;
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain got=%b want=0", outValid); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_add_wrap();
        test_sub_compare();
        test_shifts();
        test_reset_mid_mul();
        test_mul_backpressure();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
